// File: rtl/pad_io_adapter.sv
// pad_io_adapter
//   Bridges narrow chip pads and the wide core datapath.
//   Input side: collects BEATS = CORE_W/PAD_W contiguous pad beats (LS slice
//   first) into one core word, with size/action sideband taken from beat 0.
//   Output side: core results go into a small FIFO and are shifted out
//   LS slice first, back-to-back when more words are waiting.
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   pad_in_valid/data, pad_size/action  input beats and sideband
//   core_in_valid/data/size/action    assembled word (one-cycle pulse)
//   core_out_valid/data, core_out_ready  core result push into FIFO
//   pad_out_valid/data, pad_oen       output beats and pad drive enable
//   err_frame, err_ovf                sticky truncation / overflow flags
module pad_io_adapter #(
   parameter int CORE_W     = 32,
   parameter int PAD_W      = 8,
   parameter int SIZE_W     = 2,
   parameter int ACT_W      = 3,
   parameter int OBUF_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pad_in_valid,
   input  logic [PAD_W-1:0]  pad_in_data,
   input  logic [SIZE_W-1:0] pad_size,
   input  logic [ACT_W-1:0]  pad_action,
   output logic              core_in_valid,
   output logic [CORE_W-1:0] core_in_data,
   output logic [SIZE_W-1:0] core_size,
   output logic [ACT_W-1:0]  core_action,
   input  logic              core_out_valid,
   input  logic [CORE_W-1:0] core_out_data,
   output logic              core_out_ready,
   output logic              pad_out_valid,
   output logic [PAD_W-1:0]  pad_out_data,
   output logic              pad_oen,
   output logic              err_frame,
   output logic              err_ovf
);
   localparam int BEATS = CORE_W / PAD_W;
   localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int PW    = $clog2(OBUF_DEPTH);
   localparam int OCW   = PW + 1;
   localparam logic [BCW-1:0] LAST = BCW'(BEATS - 1);
   localparam logic [OCW-1:0] FULL = OCW'(OBUF_DEPTH);

   // ---------------- deserialiser ----------------
   logic [BCW-1:0]    in_cnt;
   logic [CORE_W-1:0] asm_q, asm_d;
   logic [SIZE_W-1:0] size_q;
   logic [ACT_W-1:0]  act_q;

   // Word including the beat on the pins now, so the final beat can be
   // published in the same edge it is sampled.
   always_comb begin
      asm_d = asm_q;
      asm_d[int'(in_cnt)*PAD_W +: PAD_W] = pad_in_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_cnt        <= '0;
         asm_q         <= '0;
         size_q        <= '0;
         act_q         <= '0;
         core_in_valid <= 1'b0;
         core_in_data  <= '0;
         core_size     <= '0;
         core_action   <= '0;
         err_frame     <= 1'b0;
      end else begin
         core_in_valid <= 1'b0;
         if (pad_in_valid) begin
            asm_q <= asm_d;
            if (in_cnt == '0) begin
               size_q <= pad_size;
               act_q  <= pad_action;
            end
            if (in_cnt == LAST) begin
               in_cnt        <= '0;
               core_in_valid <= 1'b1;
               core_in_data  <= asm_d;
               // single-beat words take sideband straight from the pins
               core_size     <= (in_cnt == '0) ? pad_size   : size_q;
               core_action   <= (in_cnt == '0) ? pad_action : act_q;
            end else begin
               in_cnt <= in_cnt + 1'b1;
            end
         end else if (in_cnt != '0) begin
            // gap inside a word: drop the partial word
            in_cnt    <= '0;
            err_frame <= 1'b1;
         end
      end
   end

   // ---------------- output FIFO ----------------
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t            state;
   logic [BCW-1:0]    out_cnt;
   logic [CORE_W-1:0] sreg;
   logic [CORE_W-1:0] mem [OBUF_DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [OCW-1:0]    occ, occ_d;
   logic              push, pop;

   assign push = core_out_valid & core_out_ready;
   // serialiser takes a word when idle or while emitting the last beat
   assign pop  = (occ != '0) && ((state == IDLE) || (out_cnt == LAST));

   always_comb begin
      occ_d = occ;
      if (push && !pop)      occ_d = occ + 1'b1;
      else if (pop && !push) occ_d = occ - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= core_out_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         occ            <= '0;
         core_out_ready <= 1'b0;
         err_ovf        <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         occ            <= occ_d;
         core_out_ready <= (occ_d < FULL);
         if (core_out_valid && !core_out_ready) err_ovf <= 1'b1;
      end
   end

   // ---------------- serialiser ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         out_cnt       <= '0;
         sreg          <= '0;
         pad_out_valid <= 1'b0;
         pad_out_data  <= '0;
         pad_oen       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               pad_out_valid <= 1'b0;
               pad_out_data  <= '0;
               pad_oen       <= 1'b0;
               if (pop) begin
                  sreg    <= mem[rd_ptr];
                  out_cnt <= '0;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               pad_out_valid <= 1'b1;
               pad_out_data  <= sreg[int'(out_cnt)*PAD_W +: PAD_W];
               pad_oen       <= 1'b1;
               if (out_cnt == LAST) begin
                  out_cnt <= '0;
                  if (pop) sreg  <= mem[rd_ptr];
                  else     state <= IDLE;
               end else begin
                  out_cnt <= out_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pad_io_adapter.sv
// Directed bench for pad_io_adapter: PAD_W=8 main instance, plus PAD_W=16
// and PAD_W=32 instances exercised for reset and single/dual-beat words.
module tb_pad_io_adapter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic [1:0]  psize;
   logic [2:0]  pact;
   logic        cov;
   logic [31:0] cod;
   logic        iv8, iv16, iv32;
   logic [7:0]  id8;
   logic [15:0] id16;
   logic [31:0] id32;

   logic civ8, civ16, civ32, cor8, cor16, cor32, pov8, pov16, pov32;
   logic oen8, oen16, oen32, efr8, efr16, efr32, eov8, eov16, eov32;
   logic [31:0] cid8, cid16, cid32;
   logic [1:0]  csz8, csz16, csz32;
   logic [2:0]  cact8, cact16, cact32;
   logic [7:0]  pod8;
   logic [15:0] pod16;
   logic [31:0] pod32;

   pad_io_adapter #(.PAD_W(8)) u8 (
      .clk(clk), .rst(rst), .pad_in_valid(iv8), .pad_in_data(id8),
      .pad_size(psize), .pad_action(pact), .core_in_valid(civ8),
      .core_in_data(cid8), .core_size(csz8), .core_action(cact8),
      .core_out_valid(cov), .core_out_data(cod), .core_out_ready(cor8),
      .pad_out_valid(pov8), .pad_out_data(pod8), .pad_oen(oen8),
      .err_frame(efr8), .err_ovf(eov8));
   pad_io_adapter #(.PAD_W(16)) u16 (
      .clk(clk), .rst(rst), .pad_in_valid(iv16), .pad_in_data(id16),
      .pad_size(psize), .pad_action(pact), .core_in_valid(civ16),
      .core_in_data(cid16), .core_size(csz16), .core_action(cact16),
      .core_out_valid(cov), .core_out_data(cod), .core_out_ready(cor16),
      .pad_out_valid(pov16), .pad_out_data(pod16), .pad_oen(oen16),
      .err_frame(efr16), .err_ovf(eov16));
   pad_io_adapter #(.PAD_W(32)) u32 (
      .clk(clk), .rst(rst), .pad_in_valid(iv32), .pad_in_data(id32),
      .pad_size(psize), .pad_action(pact), .core_in_valid(civ32),
      .core_in_data(cid32), .core_size(csz32), .core_action(cact32),
      .core_out_valid(cov), .core_out_data(cod), .core_out_ready(cor32),
      .pad_out_valid(pov32), .pad_out_data(pod32), .pad_oen(oen32),
      .err_frame(efr32), .err_ovf(eov32));

   int ntests = 0;
   int nfail  = 0;
   int npulse = 0;
   int noen   = 0;
   int cyc    = 0;
   logic [7:0] bq[$];
   int         bc[$];

   // posedge sees pre-edge values, so each visible cycle is counted once
   always @(posedge clk) begin
      if (civ8) npulse++;
      if (oen8) noen++;
      if (pov8) begin
         bq.push_back(pod8);
         bc.push_back(cyc);
      end
      cyc++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic beat8(input logic [7:0] d);
      iv8 = 1'b1; id8 = d; tick();
   endtask

   int p0;
   int acc[7] = '{0, 1, 2, 3, 4, 6, 10};

   initial begin
      rst = 1'b1; psize = '0; pact = '0; cov = 1'b0; cod = '0;
      iv8 = 1'b0; iv16 = 1'b0; iv32 = 1'b0; id8 = '0; id16 = '0; id32 = '0;
      tick(2);
      // reset state
      chk("rst_civ", civ8, 0);
      chk("rst_cid", cid8, 0);
      chk("rst_ready", {cor8, cor16, cor32}, 0);
      chk("rst_pov_oen", {pov8, oen8, pod8}, 0);
      chk("rst_err", {efr8, eov8}, 0);
      rst = 1'b0;
      tick();
      chk("ready_after_rst", cor8, 1);

      // 1: simple word, sideband from beat 0 only
      p0 = npulse;
      psize = 2'd2; pact = 3'd5; beat8(8'h44);
      psize = 2'd0; pact = 3'd0; beat8(8'h33);
      beat8(8'h22);
      beat8(8'h11);
      chk("t1_pulse", civ8, 1);
      chk("t1_data", cid8, 32'h11223344);
      chk("t1_size", csz8, 2);
      chk("t1_act", cact8, 5);
      iv8 = 1'b0;
      tick();
      chk("t1_pulse_end", civ8, 0);
      chk("t1_hold", cid8, 32'h11223344);
      chk("t1_npulse", npulse - p0, 1);
      chk("t1_noerr", efr8, 0);

      // 2: truncated word then a clean one
      p0 = npulse;
      beat8(8'h01);
      beat8(8'h02);
      iv8 = 1'b0; tick();
      chk("t2_err_frame", efr8, 1);
      chk("t2_no_pulse", civ8, 0);
      beat8(8'hAA); beat8(8'hAA); beat8(8'hAA); beat8(8'hAA);
      iv8 = 1'b0;
      chk("t2_pulse", civ8, 1);
      chk("t2_data", cid8, 32'hAAAAAAAA);
      tick();
      chk("t2_npulse", npulse - p0, 1);

      // 3: single push, latency and beat order
      tick(2);
      noen = 0;
      cov = 1'b1; cod = 32'hDEADBEEF; tick();
      cov = 1'b0;
      chk("t3_idle_t", pov8, 0);
      tick();
      chk("t3_idle_t1", pov8, 0);
      tick();
      chk("t3_b0", {pov8, oen8, pod8}, {2'b11, 8'hEF});
      tick();
      chk("t3_b1", {pov8, oen8, pod8}, {2'b11, 8'hBE});
      tick();
      chk("t3_b2", {pov8, oen8, pod8}, {2'b11, 8'hAD});
      tick();
      chk("t3_b3", {pov8, oen8, pod8}, {2'b11, 8'hDE});
      tick();
      chk("t3_done", {pov8, oen8, pod8}, 0);
      tick();
      chk("t3_oen_cycles", noen, 4);

      // 4: five pushes back to back, all accepted, 20 gap-free beats
      tick(2);
      bq.delete(); bc.delete();
      for (int i = 0; i < 5; i++) begin
         cov = 1'b1;
         cod = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
         tick();
      end
      cov = 1'b0;
      tick(25);
      chk("t4_nbeats", bq.size(), 20);
      if (bq.size() == 20) begin
         for (int k = 0; k < 20; k++) chk("t4_beat", bq[k], 64'(k));
         chk("t4_contig", bc[19] - bc[0], 19);
      end
      chk("t4_no_ovf", eov8, 0);

      // 5: push every cycle for 12 cycles; words 0-4, 6 and 10 fit
      bq.delete(); bc.delete();
      for (int i = 0; i < 12; i++) begin
         cov = 1'b1;
         cod = {8'(16*i+3), 8'(16*i+2), 8'(16*i+1), 8'(16*i)};
         tick();
         if (i == 4) chk("t5_ready_low", cor8, 0);
      end
      cov = 1'b0;
      tick(40);
      chk("t5_ovf", eov8, 1);
      chk("t5_nbeats", bq.size(), 28);
      if (bq.size() == 28) begin
         for (int j = 0; j < 28; j++) chk("t5_beat", bq[j], 64'(16*acc[j/4] + j%4));
         chk("t5_contig", bc[27] - bc[0], 27);
      end

      // 6: reset during shift and mid input word, on all three widths
      for (int i = 0; i < 3; i++) begin
         cov = 1'b1; cod = 32'h55667788 + 32'(i); tick();
      end
      cov = 1'b0;
      tick(2);
      iv8 = 1'b1; id8 = 8'h99; iv16 = 1'b1; id16 = 16'h1234; tick();
      chk("t6_pre_shift", pov8, 1);
      rst = 1'b1; id8 = 8'h98; id16 = 16'h5678; tick();
      iv8 = 1'b0; iv16 = 1'b0;
      chk("t6_rst_u8", {civ8, cid8, csz8, cact8, cor8, pov8, pod8, oen8, efr8, eov8}, 0);
      chk("t6_rst_u16", {civ16, cid16, csz16, cact16, cor16, pov16, pod16, oen16, efr16, eov16}, 0);
      chk("t6_rst_u32", {civ32, csz32, cact32, cor32, pov32, oen32, efr32, eov32}, 0);
      chk("t6_rst_u32_data", {cid32, pod32}, 0);
      rst = 1'b0; tick();
      chk("t6_ready", {cor8, cor16, cor32}, 3'b111);
      bq.delete(); bc.delete();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6_fifo_empty", {pov8, pov16, pov32}, 0);
      end
      // clean words after reset
      psize = 2'd1; pact = 3'd3;
      iv8 = 1'b1; id8 = 8'h0D; iv16 = 1'b1; id16 = 16'hBEEF;
      iv32 = 1'b1; id32 = 32'h12345678; tick();
      chk("t6_u32_word", {civ32, cid32, csz32, cact32}, {1'b1, 32'h12345678, 2'd1, 3'd3});
      psize = 2'd0; pact = 3'd0; iv32 = 1'b0;
      id8 = 8'h0C; id16 = 16'hCAFE; tick();
      chk("t6_u16_word", {civ16, cid16, csz16, cact16}, {1'b1, 32'hCAFEBEEF, 2'd1, 3'd3});
      chk("t6_u32_one_pulse", civ32, 0);
      iv16 = 1'b0;
      id8 = 8'h0B; tick();
      id8 = 8'h0A; tick();
      iv8 = 1'b0;
      chk("t6_u8_word", {civ8, cid8, csz8, cact8}, {1'b1, 32'h0A0B0C0D, 2'd1, 3'd3});
      chk("t6_no_frame_err", {efr8, efr16, efr32}, 0);
      cov = 1'b1; cod = 32'h89ABCDEF; tick();
      cov = 1'b0; tick(2);
      chk("t6_u16_b0", {pov16, oen16, pod16}, {2'b11, 16'hCDEF});
      chk("t6_u32_b0", {pov32, oen32, pod32}, {2'b11, 32'h89ABCDEF});
      tick();
      chk("t6_u16_b1", {pov16, oen16, pod16}, {2'b11, 16'h89AB});
      chk("t6_u32_done", {pov32, oen32, pod32}, 0);
      tick();
      chk("t6_u16_done", {pov16, oen16, pod16}, 0);
      tick(4);
      chk("t6_u8_nbeats", bq.size(), 4);
      if (bq.size() == 4)
         chk("t6_u8_beats", {bq[0], bq[1], bq[2], bq[3]}, 32'hEFCDAB89);
      chk("t6_no_ovf", {eov8, eov16, eov32}, 0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
